// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared constants and channel state encoding for the ATM timeout scheduler
package atm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    // 625000 cycles per base tick is 10 ms at a 62.5 MHz system clock
    localparam int TICK_DIV_DEFAULT = 625000;

    localparam int CH_CARD  = 0;
    localparam int CH_PIN   = 1;
    localparam int CH_IDLE  = 2;
    localparam int CH_BLINK = 3;

endpackage

// File: rtl/timeout_channel.sv
// rtl/timeout_channel.sv - one timeout channel: IDLE/RUN FSM with a remaining-tick counter
module timeout_channel
    import atm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             busy,
    output logic             expired
);

    ch_state_e        state_q;
    logic [CNT_W-1:0] rem_q;
    logic             expired_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (start) begin
                rem_q <= load_val;
                if (load_val == '0) begin
                    state_q   <= ST_IDLE;
                    expired_q <= 1'b1;
                end else begin
                    state_q <= ST_RUN;
                end
            end else if (state_q == ST_RUN) begin
                if (cancel) begin
                    state_q <= ST_IDLE;
                end else if (tick) begin
                    // rem is never 0 while running, so this is the final tick when rem is 1
                    if (rem_q > CNT_W'(1)) begin
                        rem_q <= rem_q - CNT_W'(1);
                    end else begin
                        state_q   <= ST_IDLE;
                        expired_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign expired = expired_q;

endmodule

// File: rtl/atm_timeout_scheduler.sv
// rtl/atm_timeout_scheduler.sv - shared base-tick prescaler driving N independent timeout channels
module atm_timeout_scheduler
    import atm_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [N_CH-1:0]       start,
    input  logic [N_CH-1:0]       cancel,
    input  logic [N_CH*CNT_W-1:0] load_val,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       expired,
    output logic                  tick
);

    localparam int                PCNT_W   = $clog2(TICK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);

    logic              any_busy;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic [PCNT_W-1:0] pcnt;

    assign any_busy = |busy;
    // Masking keeps the prescaler reading 0 in the very cycle the last channel drops out
    assign pcnt     = any_busy ? pcnt_q : '0;
    assign tick     = any_busy && (pcnt == PCNT_MAX);

    always_comb begin
        pcnt_d = '0;
        if (any_busy && (pcnt != PCNT_MAX)) begin
            pcnt_d = pcnt + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        timeout_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .start    (start[i]),
            .cancel   (cancel[i]),
            .load_val (load_val[i*CNT_W +: CNT_W]),
            .tick     (tick),
            .busy     (busy[i]),
            .expired  (expired[i])
        );
    end

endmodule

// File: tb/tb_atm_timeout_scheduler.sv
// tb/tb_atm_timeout_scheduler.sv - directed scoreboard bench for atm_timeout_scheduler
module tb_atm_timeout_scheduler;

    localparam int TD = 4;
    localparam int NC = 4;
    localparam int CW = 8;

    logic          clk_in = 1'b0;
    logic          rst;
    logic [NC-1:0] start;
    logic [NC-1:0] cancel;
    logic [NC*CW-1:0] load_val;
    logic [NC-1:0] busy;
    logic [NC-1:0] expired;
    logic          tick;

    atm_timeout_scheduler #(
        .TICK_DIV (TD),
        .N_CH     (NC),
        .CNT_W    (CW)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .start    (start),
        .cancel   (cancel),
        .load_val (load_val),
        .busy     (busy),
        .expired  (expired),
        .tick     (tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [8:0] v;
        int         tst;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur   = 0;
    int   tst   = 0;

    task automatic push(input int c, input logic [3:0] b, input logic [3:0] e, input logic t);
        exp_t x;
        x.v   = {b, e, t};
        x.tst = tst;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic cyc();
        exp_t       x;
        logic [8:0] obs;
        @(posedge clk_in);
        #1;
        cur++;
        obs = {busy, expired, tick};
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL t%0d c%0d scoreboard_empty observed=%b expected=none", tst, cur, obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.v && x.cyc == cur) else begin
                n_bad++;
                $error("FAIL t%0d c%0d busy/expired/tick observed=%b (cycle %0d) expected=%b (cycle %0d)",
                       x.tst, x.cyc, obs, cur, x.v, x.cyc);
            end
        end
    endtask

    task automatic check_pcnt_zero(input string tag);
        n_cmp++;
        assert (dut.pcnt === 2'd0) else begin
            n_bad++;
            $error("FAIL %s pcnt observed=%0d expected=0", tag, dut.pcnt);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = '0;
        cancel   = '0;
        load_val = '0;

        // 1: reset held with all starts asserted, then released
        tst = 1; cur = 0;
        for (int c = 1; c <= 6; c++) push(c, 4'b0000, 4'b0000, 1'b0);
        start    = 4'hF;
        load_val = 32'h0303_0303;
        repeat (3) cyc();
        rst   = 1'b0;
        start = '0;
        repeat (3) cyc();

        // 2: single channel, load 3
        tst = 2; cur = 0;
        for (int c = 1; c <= 16; c++)
            push(c, {3'b000, (c <= 12)}, {3'b000, (c == 13)}, (c == 4 || c == 8 || c == 12));
        start    = 4'b0001;
        load_val = 32'h0000_0003;
        cyc();
        start = '0;
        repeat (15) cyc();

        // 3a: zero load expires immediately without going busy
        tst = 3; cur = 0;
        push(1, 4'b0000, 4'b0010, 1'b0);
        push(2, 4'b0000, 4'b0000, 1'b0);
        start    = 4'b0010;
        load_val = 32'h0000_0000;
        cyc();
        start = '0;
        cyc();

        // 3b: cancel at edge 6
        tst = 4; cur = 0;
        for (int c = 1; c <= 10; c++)
            push(c, {1'b0, (c <= 6), 2'b00}, 4'b0000, (c == 4));
        start    = 4'b0100;
        load_val = 32'h0005_0000;
        cyc();
        start = '0;
        while (cur < 6) cyc();
        cancel = 4'b0100;
        cyc();
        cancel = '0;
        check_pcnt_zero("cancel_last_pcnt");
        repeat (3) cyc();

        // 4: second channel joins the running tick phase
        tst = 5; cur = 0;
        for (int c = 1; c <= 15; c++)
            push(c, {2'b00, (c >= 3 && c <= 8), (c <= 12)},
                 {2'b00, (c == 9), (c == 13)}, ((c % 4) == 0 && c <= 12));
        start    = 4'b0001;
        load_val = 32'h0000_0203;
        cyc();
        start = '0;
        cyc();
        start = 4'b0010;
        cyc();
        start = '0;
        repeat (12) cyc();

        // 5a: start beats cancel on the same edge
        tst = 6; cur = 0;
        for (int c = 1; c <= 11; c++)
            push(c, {(c <= 8), 3'b000}, {(c == 9), 3'b000}, (c == 4 || c == 8));
        start    = 4'b1000;
        cancel   = 4'b1000;
        load_val = 32'h0200_0000;
        cyc();
        start  = '0;
        cancel = '0;
        repeat (10) cyc();

        // 5b: restart on the final tick edge reloads instead of expiring
        tst = 7; cur = 0;
        for (int c = 1; c <= 18; c++)
            push(c, {3'b000, (c <= 16)}, {3'b000, (c == 17)}, ((c % 4) == 0 && c <= 16));
        start    = 4'b0001;
        load_val = 32'h0000_0002;
        cyc();
        start = '0;
        while (cur < 8) cyc();
        start = 4'b0001;
        cyc();
        start = '0;
        while (cur < 18) cyc();

        // 6: reset while all channels run
        tst = 8; cur = 0;
        for (int c = 1; c <= 9; c++)
            push(c, (c <= 6) ? 4'hF : 4'h0, 4'h0, (c == 4));
        start    = 4'hF;
        load_val = 32'h0A0A_0A0A;
        cyc();
        start = '0;
        while (cur < 6) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_pcnt_zero("reset_pcnt");
        repeat (2) cyc();

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
